// File: rtl/rtc_time_counter_if.sv
// Signal bundle between the set-time path, the timekeeping core and the display stage.
interface rtc_time_counter_if;
    logic       time_format;
    logic       run;
    logic       load;
    logic [4:0] h_in;
    logic [5:0] m_in;
    logic [5:0] s_in;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       pm;
    logic       sec_pulse;
    logic       day_wrap;
    logic       load_err;

    modport master (
        output time_format, run, load, h_in, m_in, s_in,
        input  hours, minutes, seconds, pm, sec_pulse, day_wrap, load_err
    );

    modport slave (
        input  time_format, run, load, h_in, m_in, s_in,
        output hours, minutes, seconds, pm, sec_pulse, day_wrap, load_err
    );
endinterface

// File: rtl/rtc_time_counter.sv
// Time-of-day core: 1 Hz prescaler, binary hh:mm:ss with validated load,
// and 24 h / 12 h hour presentation with a PM flag.
module rtc_time_counter #(
    parameter int unsigned TICKS_PER_SEC = 100000000
) (
    input  logic                clk,
    input  logic                reset,
    rtc_time_counter_if.slave   bus
);
    localparam int unsigned PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc;
    logic [4:0]    hr24;
    logic [5:0]    min;
    logic [5:0]    sec;
    logic          sec_pulse_r;
    logic          day_wrap_r;
    logic          load_err_r;

    logic tick;
    logic load_ok;

    assign tick    = bus.run && (presc == PRESC_MAX);
    assign load_ok = (bus.h_in <= 5'd23) && (bus.m_in <= 6'd59) && (bus.s_in <= 6'd59);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc       <= '0;
            hr24        <= '0;
            min         <= '0;
            sec         <= '0;
            sec_pulse_r <= 1'b0;
            day_wrap_r  <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            sec_pulse_r <= 1'b0;
            day_wrap_r  <= 1'b0;
            load_err_r  <= 1'b0;

            if (bus.run) begin
                presc <= tick ? '0 : presc + PW'(1);
            end

            // A valid load overrides both the prescaler step and any tick in the same cycle.
            if (bus.load && load_ok) begin
                hr24  <= bus.h_in;
                min   <= bus.m_in;
                sec   <= bus.s_in;
                presc <= '0;
            end else begin
                if (bus.load) begin
                    load_err_r <= 1'b1;
                end
                if (tick) begin
                    sec_pulse_r <= 1'b1;
                    if (sec == 6'd59) begin
                        sec <= '0;
                        if (min == 6'd59) begin
                            min <= '0;
                            if (hr24 == 5'd23) begin
                                hr24       <= '0;
                                day_wrap_r <= 1'b1;
                            end else begin
                                hr24 <= hr24 + 5'd1;
                            end
                        end else begin
                            min <= min + 6'd1;
                        end
                    end else begin
                        sec <= sec + 6'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.hours = hr24;
        if (bus.time_format) begin
            if (hr24 == 5'd0) begin
                bus.hours = 5'd12;
            end else if (hr24 > 5'd12) begin
                bus.hours = hr24 - 5'd12;
            end
        end
    end

    assign bus.pm        = (hr24 >= 5'd12);
    assign bus.minutes   = min;
    assign bus.seconds   = sec;
    assign bus.sec_pulse = sec_pulse_r;
    assign bus.day_wrap  = day_wrap_r;
    assign bus.load_err  = load_err_r;
endmodule

// File: doc/rtc_time_counter.md
Name: rtc_time_counter

Overview:
Timekeeping core that maintains the running time of day as binary hours/minutes/seconds. It feeds the digit-split and seven-segment decode stage of the clock system. It divides the board clock into a 1 Hz tick internally and accepts a synchronous load from the set-time path. It presents hours in either 24 h or 12 h form, with a PM flag.

Parameters:
TICKS_PER_SEC, 100000000, clk cycles per second; must be >= 2; prescaler width is $clog2(TICKS_PER_SEC).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high; clears all state
time_format  input  1  0 = 24 h display, 1 = 12 h display
run  input  1  1 = time advances; 0 = prescaler and time frozen
load  input  1  single-cycle load strobe from set-time path
h_in  input  5  load value, hours, always 24 h form (0..23)
m_in  input  6  load value, minutes (0..59)
s_in  input  6  load value, seconds (0..59)
hours  output  5  displayed hours (0..23 or 1..12)
minutes  output  6  minutes 0..59
seconds  output  6  seconds 0..59
pm  output  1  1 when internal hour >= 12 (valid in both formats)
sec_pulse  output  1  one-cycle pulse on every seconds update from the tick
day_wrap  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover
load_err  output  1  one-cycle pulse when a load was rejected

Behaviour:
- State registers: presc (0..TICKS_PER_SEC-1), hr24 (0..23), min (0..59), sec (0..59), plus registered pulses sec_pulse, day_wrap, load_err.
- Reset (async assert, released on clk): presc=0, hr24=0, min=0, sec=0, all pulses 0. Outputs after reset: hours=0 (24 h) or 12 (12 h), minutes=0, seconds=0, pm=0.
- Prescaler: when run=1, presc increments each clk. At TICKS_PER_SEC-1 it wraps to 0 and generates an internal tick in that cycle. When run=0, presc holds and no tick occurs.
- Tick, registered on the same clk edge as the presc wrap:
  - sec+1; at 59, wraps to 0 and carries to min.
  - min at 59 wraps to 0 and carries to hr24.
  - hr24 at 23 wraps to 0.
  - sec_pulse=1 in the cycle the new seconds value first appears.
  - day_wrap=1 in that same cycle only on a full 23:59:59 -> 00:00:00 rollover.
- Load, when load=1:
  - If h_in<=23, m_in<=59 and s_in<=59: hr24/min/sec take the inputs on the next edge, presc is cleared to 0, and no sec_pulse is generated.
  - Otherwise: state is unchanged (presc keeps counting if run=1) and load_err=1 for one cycle.
- Load and tick in the same cycle: a valid load wins and the tick is discarded. An invalid load does not block the tick, so sec_pulse and load_err may both assert.
- Load works regardless of run.
- Pulses are 0 in every cycle other than those defined above.
- Display conversion is combinational from hr24 and time_format, so a format change is visible in the same cycle:
  - 24 h: hours=hr24.
  - 12 h: hr24=0 -> 12; 1..12 -> hr24; 13..23 -> hr24-12.
  - pm = (hr24>=12), independent of format.
- minutes/seconds outputs are direct register values, never outside 0..59. Hours is never 0 in 12 h mode and never >23.
- Reset asserted mid-second clears presc, so the first tick after release comes TICKS_PER_SEC cycles after the first active edge.
- Latency: time outputs change exactly one edge after the wrap cycle or the load cycle.

Test Plan:
1. TICKS_PER_SEC=4, run=1 from reset -> seconds steps 0,1,2,3 at cycles 4,8,12 after release; one sec_pulse per step; hours=0, pm=0.
2. Load 23:59:58, run=1 -> 23:59:59 after 4 cycles, then 00:00:00 with day_wrap=1 and sec_pulse=1 in the same cycle; day_wrap=0 on every other tick.
3. Load 00:30:00, then 12:00:00, then 13:05:00 with time_format=1 -> hours=12, pm=0; hours=12, pm=1; hours=1, pm=1. Switch to time_format=0 -> hours=13 in the same cycle.
4. Load h_in=24 (and separately m_in=60) -> load_err pulse, time unchanged; valid load 10:20:30 asserted on the presc-wrap cycle -> outputs 10:20:30, no sec_pulse, next tick 4 cycles later.
5. run=0 for 10 cycles mid-second -> time and presc frozen, no pulses; run=1 -> tick after the remaining cycles of that second.
6. Assert reset asynchronously between clk edges at 05:06:07 -> outputs 0:0:0 immediately; in 12 h mode hours=12; first tick 4 cycles after release.
